xga_timing_gen: RTL and testbench
=================================

Name: xga_timing_gen

Overview:
- 1024x768@60 (VESA XGA) raster timing generator clocked from the 65 MHz PLL output; consumes the PLL `locked` flag.
- Qualifies `locked` and holds the raster idle until the PLL is stable.
- Produces registered hsync/vsync/de plus pixel coordinates and line/frame strobes for the UK101 video path (character generator / VGA DAC).

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- LOCK_HOLD, 1024, consecutive synced-locked cycles required before running

Ports:
- clk  in  1  65 MHz pixel clock
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock flag, asynchronous to clk
- hsync  out  1  horizontal sync, polarity per H_POL
- vsync  out  1  vertical sync, polarity per V_POL
- de  out  1  data enable; high in the active area
- x  out  11  horizontal counter (0..H_TOTAL-1)
- y  out  10  vertical counter (0..V_TOTAL-1)
- line_start  out  1  one-cycle pulse when x==0
- frame_start  out  1  one-cycle pulse when x==0 and y==0
- running  out  1  high while in RUN state

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344; V_TOTAL = 806.
- Reset (rst_n low, async): state IDLE, counters 0, de/line_start/frame_start/running = 0, x = y = 0, hsync = !H_POL, vsync = !V_POL (inactive).
- Lock sync: 2-flop synchroniser on pll_locked producing locked_s.
- FSM:
  - IDLE: stability counter cleared. Go to WAIT when locked_s=1.
  - WAIT: stability counter increments each cycle locked_s=1. If locked_s=0, return to IDLE. When counter == LOCK_HOLD-1, go to RUN.
  - RUN: raster counters advance. If locked_s=0, go to IDLE; counters clear and outputs return to reset values on the next edge, even mid-line or mid-frame.
- Counters (RUN only):
  - hc increments 0..H_TOTAL-1 and wraps to 0.
  - vc increments when hc == H_TOTAL-1 and wraps from V_TOTAL-1 to 0.
  - Counters are 0 on the first RUN cycle.
- Output decode, all registered, one-cycle latency, so all outputs stay mutually aligned:
  - de = (hc < H_ACTIVE) && (vc < V_ACTIVE).
  - hsync active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [1048, 1183].
  - vsync active for vc in [771, 776]; vsync changes only on the cycle where x==0.
  - x = hc, y = vc (registered); x/y keep counting in blanking.
- Latency: with pll_locked rising before edge 1, running and the first de=1 (x=0, y=0, frame_start=1) appear after edge LOCK_HOLD+3.
- Outside RUN, all outputs hold their reset values.

Optional Feature:
- Macro: XGA_TEST_PATTERN_EN.
- Defined: adds output pat_rgb [2:0], registered in the same stage as de. pat_rgb = de ? ~x[9:7] : 3'b000, giving 8 colour bars of 128 px (white first, black last).
- Undefined: the port is absent and there is no logic.

Decomposition:
- Package xga_timing_pkg holds:
  - default H/V constants;
  - derived H_TOTAL, V_TOTAL;
  - counter widths HCW=11, VCW=10;
  - FSM state typedef (IDLE, WAIT, RUN).
- Sub-module pll_lock_qualifier holds the 2-flop sync, the stability counter and the IDLE/WAIT/RUN FSM, and outputs `running`. The top level contains the counters and output decode.

Test Plan:
- Reset/idle: rst_n=0, pll_locked=0 -> hsync=vsync=1, de=0, x=y=0, running=0; still true 5000 cycles after release with pll_locked low.
- Lock qualification (LOCK_HOLD=1024): pll_locked rises -> running=1 and frame_start=1 exactly after edge 1027. A 500-cycle glitch low during WAIT restarts the count.
- Line timing: in RUN, the de high run is 1024 cycles, hsync low run is 136 cycles starting at x=1048, line_start period is 1344 cycles.
- Frame timing: frame_start period is 1083264 cycles; vsync low for 8064 cycles starting with x=0, y=771; de=0 for y 768..805.
- Lock loss mid-frame: drop pll_locked at x=500, y=300 -> outputs reach reset values 3 edges later. Re-lock yields a fresh frame starting at x=0, y=0.
- XGA_TEST_PATTERN_EN: pat_rgb=7 at x=0, 6 at x=128, 0 at x=896..1023, 0 during blanking.

Source files
------------

// File: rtl/xga_timing_pkg.sv
// Shared constants and types for the XGA (1024x768@60, 65 MHz) raster timing generator.
package xga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE  = 1024;
  localparam int unsigned DEF_H_FP      = 24;
  localparam int unsigned DEF_H_SYNC    = 136;
  localparam int unsigned DEF_H_BP      = 160;
  localparam int unsigned DEF_V_ACTIVE  = 768;
  localparam int unsigned DEF_V_FP      = 3;
  localparam int unsigned DEF_V_SYNC    = 6;
  localparam int unsigned DEF_V_BP      = 29;
  localparam bit          DEF_H_POL     = 1'b0;
  localparam bit          DEF_V_POL     = 1'b0;
  localparam int unsigned DEF_LOCK_HOLD = 1024;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned HCW = 11;
  localparam int unsigned VCW = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RUN
  } lock_state_t;

endpackage

// File: rtl/xga_timing_gen_lock.sv
// PLL lock qualifier: synchronises pll_locked, requires LOCK_HOLD stable cycles, runs IDLE/WAIT/RUN FSM.
module pll_lock_qualifier
  import xga_timing_pkg::*;
#(
  parameter int unsigned LOCK_HOLD = DEF_LOCK_HOLD
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pll_locked,
  output logic o_run_next,
  output logic o_running
);

  localparam int unsigned    CW       = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(LOCK_HOLD - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  lock_state_t   r_state;
  logic          r_running;
  logic          w_locked_s;
  logic          w_run_next;

  assign w_locked_s = r_sync[1];

  // Next-cycle RUN decision is exported so the raster stage can register its
  // first pixel on the same edge that running rises.
  assign w_run_next = w_locked_s &&
                      ((r_state == RUN) || ((r_state == WAIT) && (r_cnt == CNT_LAST)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_pll_locked};
      r_running <= w_run_next;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_locked_s) r_state <= WAIT;
        end
        WAIT: begin
          if (!w_locked_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          r_cnt <= '0;
          if (!w_locked_s) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_run_next = w_run_next;
  assign o_running  = r_running;

endmodule

// File: rtl/xga_timing_gen.sv
// XGA raster timing generator top: counters plus registered sync/de/coordinate decode.
// Optional XGA_TEST_PATTERN_EN adds pat_rgb colour-bar output.
module xga_timing_gen
  import xga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          H_POL     = DEF_H_POL,
  parameter bit          V_POL     = DEF_V_POL,
  parameter int unsigned LOCK_HOLD = DEF_LOCK_HOLD
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pll_locked,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [HCW-1:0] x,
  output logic [VCW-1:0] y,
  output logic           line_start,
  output logic           frame_start,
`ifdef XGA_TEST_PATTERN_EN
  output logic [2:0]     pat_rgb,
`endif
  output logic           running
);

  localparam logic [HCW-1:0] HA      = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_BEG  = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END  = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HCW-1:0] HC_LAST = HCW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [VCW-1:0] VA      = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_BEG  = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END  = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VCW-1:0] VC_LAST = VCW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic           w_run_next;
  logic           w_running;
  logic           w_de;
  logic           w_hs_act;
  logic           w_vs_act;
  logic [HCW-1:0] r_hc;
  logic [VCW-1:0] r_vc;
  logic           r_hsync;
  logic           r_vsync;
  logic           r_de;
  logic [HCW-1:0] r_x;
  logic [VCW-1:0] r_y;
  logic           r_line_start;
  logic           r_frame_start;

  pll_lock_qualifier #(
    .LOCK_HOLD (LOCK_HOLD)
  ) u_lock (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pll_locked (pll_locked),
    .o_run_next   (w_run_next),
    .o_running    (w_running)
  );

  always_comb begin
    w_de     = (r_hc < HA) && (r_vc < VA);
    w_hs_act = (r_hc >= HS_BEG) && (r_hc <= HS_END);
    w_vs_act = (r_vc >= VS_BEG) && (r_vc <= VS_END);
  end

  // Counters hold the pixel that the next edge registers onto the outputs, so
  // the first RUN cycle presents x=0/y=0 alongside running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!w_run_next) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_hs_act ? H_POL : ~H_POL;
      r_vsync       <= w_vs_act ? V_POL : ~V_POL;
      r_de          <= w_de;
      r_x           <= r_hc;
      r_y           <= r_vc;
      r_line_start  <= (r_hc == '0);
      r_frame_start <= (r_hc == '0) && (r_vc == '0);
      if (r_hc == HC_LAST) begin
        r_hc <= '0;
        r_vc <= (r_vc == VC_LAST) ? '0 : r_vc + 1'b1;
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end
  end

`ifdef XGA_TEST_PATTERN_EN
  logic [2:0] r_pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat <= '0;
    end else if (!w_run_next) begin
      r_pat <= '0;
    end else begin
      r_pat <= w_de ? ~r_hc[9:7] : 3'b000;
    end
  end

  assign pat_rgb = r_pat;
`endif

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign running     = w_running;

endmodule

// File: tb/tb_xga_timing_gen.sv
// Directed self-checking bench for xga_timing_gen; vertical timing shortened to 13 lines per frame.
module tb_xga_timing_gen;

  localparam int unsigned TB_V_ACTIVE = 6;
  localparam int unsigned TB_V_FP     = 2;
  localparam int unsigned TB_V_SYNC   = 3;
  localparam int unsigned TB_V_BP     = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pll_locked;
  logic        hsync, vsync, de, line_start, frame_start, running;
  logic [10:0] x;
  logic [9:0]  y;
`ifdef XGA_TEST_PATTERN_EN
  logic [2:0]  pat_rgb;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xga_timing_gen #(
    .V_ACTIVE (TB_V_ACTIVE),
    .V_FP     (TB_V_FP),
    .V_SYNC   (TB_V_SYNC),
    .V_BP     (TB_V_BP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
`ifdef XGA_TEST_PATTERN_EN
    .pat_rgb     (pat_rgb),
`endif
    .running     (running)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({hsync, vsync, de, line_start, frame_start, running} !== 6'b110000 ||
        x !== 11'd0 || y !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_state: hs=%b vs=%b de=%b ls=%b fs=%b run=%b x=%0d y=%0d, required hs=1 vs=1 de=0 ls=0 fs=0 run=0 x=0 y=0",
               hsync, vsync, de, line_start, frame_start, running, x, y);
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (5000) begin
      tick();
      if ({hsync, vsync, de, line_start, frame_start, running} !== 6'b110000 ||
          x !== 11'd0 || y !== 10'd0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL idle_hold: %0d cycles off reset values, required 0", bad);
    end
  endtask

  task automatic test_lock_glitch();
    int bad;
    pll_locked = 1'b1;
    repeat (600) tick();
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_not_running: running=%b, required 0", running);
    end
    pll_locked = 1'b0;
    bad = 0;
    repeat (500) begin
      tick();
      if (running !== 1'b0 || de !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL glitch_idle: %0d cycles running during glitch, required 0", bad);
    end
    pll_locked = 1'b1;
    bad = 0;
    for (int n = 1; n <= 1026; n++) begin
      tick();
      if (running !== 1'b0 || de !== 1'b0 || frame_start !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL lock_early: %0d cycles active before edge 1027, required 0", bad);
    end
    tick();
    n_checks++;
    if (running !== 1'b1 || frame_start !== 1'b1 || line_start !== 1'b1 || de !== 1'b1 ||
        x !== 11'd0 || y !== 10'd0) begin
      n_fail++;
      $display("FAIL lock_latency: run=%b fs=%b ls=%b de=%b x=%0d y=%0d after edge 1027, required 1 1 1 1 0 0",
               running, frame_start, line_start, de, x, y);
    end
  endtask

  task automatic test_line();
    int de_cnt, de_bad, hs_cnt, hs_first, ls_cnt, xbad;
    de_cnt = 0; de_bad = 0; hs_cnt = 0; hs_first = -1; ls_cnt = 0; xbad = 0;
    for (int c = 0; c < 1344; c++) begin
      if (x !== 11'(c)) xbad++;
      if (de === 1'b1) de_cnt++;
      if (de !== (c < 1024)) de_bad++;
      if (hsync === 1'b0) begin
        if (hs_first < 0) hs_first = int'(x);
        hs_cnt++;
      end
      if (line_start === 1'b1) ls_cnt++;
      tick();
    end
    n_checks++;
    if (xbad !== 0) begin
      n_fail++;
      $display("FAIL x_sequence: %0d cycles with wrong x, required 0", xbad);
    end
    n_checks++;
    if (de_cnt !== 1024 || de_bad !== 0) begin
      n_fail++;
      $display("FAIL de_run: de high %0d cycles (%0d misplaced), required 1024 (0)", de_cnt, de_bad);
    end
    n_checks++;
    if (hs_cnt !== 136 || hs_first !== 1048) begin
      n_fail++;
      $display("FAIL hsync_run: low %0d cycles from x=%0d, required 136 from x=1048", hs_cnt, hs_first);
    end
    n_checks++;
    if (ls_cnt !== 1 || line_start !== 1'b1 || x !== 11'd0 || y !== 10'd1) begin
      n_fail++;
      $display("FAIL line_period: ls_in_line=%0d ls=%b x=%0d y=%0d at cycle 1344, required 1 1 0 1",
               ls_cnt, line_start, x, y);
    end
  endtask

  task automatic test_frame();
    int guard, cyc, vs_cnt, vs_x, vs_y, de_cnt, blank_bad, vs_edge_bad;
    logic prev_vs;
    guard = 0;
    while (frame_start !== 1'b1 && guard < 40000) begin
      tick();
      guard++;
    end
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_start_timeout: fs=%b after %0d cycles, required 1", frame_start, guard);
    end
    cyc = 0; vs_cnt = 0; vs_x = -1; vs_y = -1; de_cnt = 0; blank_bad = 0; vs_edge_bad = 0;
    prev_vs = vsync;
    do begin
      if (vsync === 1'b0) begin
        if (vs_cnt == 0) begin
          vs_x = int'(x);
          vs_y = int'(y);
        end
        vs_cnt++;
      end
      if (vsync !== prev_vs && x !== 11'd0) vs_edge_bad++;
      prev_vs = vsync;
      if (de === 1'b1) de_cnt++;
      if (y >= 10'd6 && de !== 1'b0) blank_bad++;
      tick();
      cyc++;
    end while (frame_start !== 1'b1 && cyc < 40000);
    n_checks++;
    if (cyc !== 17472) begin
      n_fail++;
      $display("FAIL frame_period: %0d cycles, required 17472", cyc);
    end
    n_checks++;
    if (vs_cnt !== 4032 || vs_x !== 0 || vs_y !== 8) begin
      n_fail++;
      $display("FAIL vsync_run: low %0d cycles from x=%0d y=%0d, required 4032 from x=0 y=8", vs_cnt, vs_x, vs_y);
    end
    n_checks++;
    if (vs_edge_bad !== 0) begin
      n_fail++;
      $display("FAIL vsync_align: %0d vsync changes away from x=0, required 0", vs_edge_bad);
    end
    n_checks++;
    if (de_cnt !== 6144 || blank_bad !== 0) begin
      n_fail++;
      $display("FAIL frame_de: de high %0d cycles, %0d in vblank, required 6144 and 0", de_cnt, blank_bad);
    end
  endtask

`ifdef XGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int bad_black, bad_blank;
    logic [2:0] p0, p128;
    bad_black = 0; bad_blank = 0; p0 = 3'bx; p128 = 3'bx;
    for (int c = 0; c < 1344; c++) begin
      if (x === 11'd0)   p0   = pat_rgb;
      if (x === 11'd128) p128 = pat_rgb;
      if (x >= 11'd896 && x <= 11'd1023 && pat_rgb !== 3'd0) bad_black++;
      if (x >= 11'd1024 && pat_rgb !== 3'd0) bad_blank++;
      tick();
    end
    n_checks++;
    if (p0 !== 3'd7 || p128 !== 3'd6) begin
      n_fail++;
      $display("FAIL pattern_bars: pat@0=%0d pat@128=%0d, required 7 and 6", p0, p128);
    end
    n_checks++;
    if (bad_black !== 0 || bad_blank !== 0) begin
      n_fail++;
      $display("FAIL pattern_black: %0d nonzero in last bar, %0d in blanking, required 0 and 0", bad_black, bad_blank);
    end
  endtask
`endif

  task automatic test_lock_loss();
    int guard;
    guard = 0;
    while (!(x === 11'd500 && y === 10'd3) && guard < 40000) begin
      tick();
      guard++;
    end
    n_checks++;
    if (x !== 11'd500 || y !== 10'd3) begin
      n_fail++;
      $display("FAIL reach_500_3: x=%0d y=%0d, required 500 3", x, y);
    end
    pll_locked = 1'b0;
    tick();
    tick();
    n_checks++;
    if (running !== 1'b1 || x !== 11'd502 || de !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_edge2: run=%b x=%0d de=%b, required 1 502 1", running, x, de);
    end
    tick();
    n_checks++;
    if ({hsync, vsync, de, line_start, frame_start, running} !== 6'b110000 ||
        x !== 11'd0 || y !== 10'd0) begin
      n_fail++;
      $display("FAIL loss_reset: hs=%b vs=%b de=%b ls=%b fs=%b run=%b x=%0d y=%0d, required 1 1 0 0 0 0 0 0",
               hsync, vsync, de, line_start, frame_start, running, x, y);
    end
    pll_locked = 1'b1;
    repeat (1026) tick();
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL relock_early: running=%b after edge 1026, required 0", running);
    end
    tick();
    n_checks++;
    if (running !== 1'b1 || frame_start !== 1'b1 || de !== 1'b1 || x !== 11'd0 || y !== 10'd0) begin
      n_fail++;
      $display("FAIL relock_frame: run=%b fs=%b de=%b x=%0d y=%0d, required 1 1 1 0 0",
               running, frame_start, de, x, y);
    end
    tick();
    n_checks++;
    if (x !== 11'd1 || y !== 10'd0 || frame_start !== 1'b0 || line_start !== 1'b0) begin
      n_fail++;
      $display("FAIL relock_step: x=%0d y=%0d fs=%b ls=%b, required 1 0 0 0", x, y, frame_start, line_start);
    end
  endtask

  initial begin
    test_reset();
    test_lock_glitch();
    test_line();
    test_frame();
`ifdef XGA_TEST_PATTERN_EN
    test_pattern();
`endif
    test_lock_loss();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
